// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: N masters share one slave port.
// Grant is held for a whole cyc tenure; a watchdog aborts stalled strobes with err.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);
    localparam int N   = NUM_MASTERS;
    localparam int SW  = DW / 8;
    localparam int IW  = $clog2(N);
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ABORT} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    last_q, last_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic             err_pend_q, err_pend_d;

    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    cand;
    logic             win_found;
    logic             sel_cyc, sel_stb, sel_we;
    logic [AW-1:0]    sel_adr;
    logic [DW-1:0]    sel_dat;
    logic [SW-1:0]    sel_sel;
    logic             busy;

    // Rotating priority: first requester after the last one served.
    always_comb begin
        win_idx   = '0;
        cand      = '0;
        win_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_q) + k) % N);
            if (!win_found && m_cyc_i[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_cyc = m_cyc_i[gidx_q];
        sel_stb = m_stb_i[gidx_q];
        sel_we  = m_we_i[gidx_q];
        sel_adr = m_adr_i[int'(gidx_q)*AW +: AW];
        sel_dat = m_dat_i[int'(gidx_q)*DW +: DW];
        sel_sel = m_sel_i[int'(gidx_q)*SW +: SW];
    end

    always_comb begin
        busy    = (state_q == ST_BUSY);
        s_cyc_o = busy & sel_cyc;
        s_stb_o = busy & sel_cyc & sel_stb;
        s_we_o  = busy & sel_we;
        s_adr_o = busy ? sel_adr : '0;
        s_dat_o = busy ? sel_dat : '0;
        s_sel_o = busy ? sel_sel : '0;
        m_dat_o = s_dat_i;
        grant_o = grant_q;
        m_ack_o = '0;
        m_err_o = '0;
        if (busy && sel_cyc) begin
            m_ack_o[gidx_q] = s_ack_i;
            m_err_o[gidx_q] = s_err_i;
        end else if (state_q == ST_ABORT && err_pend_q) begin
            m_err_o[gidx_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        last_d     = last_q;
        wdog_d     = '0;
        err_pend_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    gidx_d           = win_idx;
                    state_d          = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!sel_cyc) begin
                    last_d  = gidx_q;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (sel_stb && !s_ack_i && !s_err_i) begin
                    // A response in the expiry cycle still completes normally.
                    if (TIMEOUT != 0 && wdog_q == WD_LAST) begin
                        state_d    = ST_ABORT;
                        err_pend_d = 1'b1;
                    end else if (TIMEOUT != 0) begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                if (!sel_cyc) begin
                    last_d  = gidx_q;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_q     <= IW'(N - 1);
            wdog_q     <= '0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_q     <= last_d;
            wdog_q     <= wdog_d;
            err_pend_q <= err_pend_d;
        end
    end
endmodule
